// File: rtl/ifft_4_stream.sv
// ifft_4_stream: streaming 4-point inverse FFT, Q1.15 in/out, scaled by 1/4.
// Define IFFT4_SAT_EN to clamp out-of-range outputs and report them on sat; otherwise outputs wrap.
module ifft_4_stream #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_real,
  input  logic [W-1:0] s_imag,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_real,
  output logic [W-1:0] m_imag,
  output logic         m_last,
  output logic         frame_err,
  output logic         sat
);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  logic [1:0] state, idx, oidx;
  logic [W-1:0] bin_re [4];
  logic [W-1:0] bin_im [4];
  logic [W-1:0] out_re [4];
  logic [W-1:0] out_im [4];
  logic [W-1:0] x_re [4];
  logic [W-1:0] x_im [4];
  logic [W+1:0] y_re [4];
  logic [W+1:0] y_im [4];
  logic [W:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic [7:0] ovf;
  // returns {overflow, value}: (y + 2) >>> 2 reduced to W bits
  function automatic logic [W:0] scale(input logic [W+1:0] y);
`ifdef IFFT4_SAT_EN
    logic [W:0] r;
    r = (W+1)'(({y[W+1], y} + (W+3)'(2)) >> 2);
    scale = (r[W] == r[W-1]) ? {1'b0, r[W-1:0]} : {1'b1, r[W], {(W-1){!r[W]}}};
`else
    scale = {1'b0, W'(({y[W+1], y} + (W+3)'(2)) >> 2)};
`endif
  endfunction
  assign s_ready   = state == LOAD;
  assign m_valid   = state == SEND;
  assign m_last    = state == SEND && oidx == 2'd3;
  assign m_real    = out_re[oidx];
  assign m_imag    = out_im[oidx];
  always_comb begin
    a_re = {bin_re[0][W-1], bin_re[0]} + {bin_re[2][W-1], bin_re[2]};
    a_im = {bin_im[0][W-1], bin_im[0]} + {bin_im[2][W-1], bin_im[2]};
    b_re = {bin_re[0][W-1], bin_re[0]} - {bin_re[2][W-1], bin_re[2]};
    b_im = {bin_im[0][W-1], bin_im[0]} - {bin_im[2][W-1], bin_im[2]};
    c_re = {bin_re[1][W-1], bin_re[1]} + {bin_re[3][W-1], bin_re[3]};
    c_im = {bin_im[1][W-1], bin_im[1]} + {bin_im[3][W-1], bin_im[3]};
    d_re = {bin_re[1][W-1], bin_re[1]} - {bin_re[3][W-1], bin_re[3]};
    d_im = {bin_im[1][W-1], bin_im[1]} - {bin_im[3][W-1], bin_im[3]};
    y_re[0] = {a_re[W], a_re} + {c_re[W], c_re};
    y_im[0] = {a_im[W], a_im} + {c_im[W], c_im};
    y_re[2] = {a_re[W], a_re} - {c_re[W], c_re};
    y_im[2] = {a_im[W], a_im} - {c_im[W], c_im};
    y_re[1] = {b_re[W], b_re} - {d_im[W], d_im};
    y_im[1] = {b_im[W], b_im} + {d_re[W], d_re};
    y_re[3] = {b_re[W], b_re} + {d_im[W], d_im};
    y_im[3] = {b_im[W], b_im} - {d_re[W], d_re};
    ovf = '0;
    for (int i = 0; i < 4; i++) begin
      {ovf[i], x_re[i]}   = scale(y_re[i]);
      {ovf[i+4], x_im[i]} = scale(y_im[i]);
    end
  end
  // framing is driven by idx alone; s_last only feeds frame_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      oidx      <= '0;
      frame_err <= 1'b0;
      sat       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bin_re[i] <= '0;
        bin_im[i] <= '0;
        out_re[i] <= '0;
        out_im[i] <= '0;
      end
    end else begin
      frame_err <= s_valid && s_ready && (s_last != (idx == 2'd3));
      if (state == LOAD && s_valid) begin
        bin_re[idx] <= s_real;
        bin_im[idx] <= s_imag;
        idx         <= idx + 2'd1;
        if (idx == 2'd3) state <= CALC;
      end
      if (state == CALC) begin
        for (int i = 0; i < 4; i++) begin
          out_re[i] <= x_re[i];
          out_im[i] <= x_im[i];
        end
        sat   <= |ovf;
        state <= SEND;
      end
      if (state == SEND && m_ready) begin
        oidx <= oidx + 2'd1;
        if (oidx == 2'd3) state <= LOAD;
      end
      if (state == 2'd3) state <= LOAD;
    end
  end
endmodule
